nco_mix_decim: RTL and testbench
================================

# nco_mix_decim

Downstream consumer of the 10 MHz NCO in the ADC test path. Multiplies each signed ADC sample by the NCO's signed 13-bit sine output, then integrates 2^DEC_LOG2 products with a boxcar integrate-and-dump. Each dumped sum is scaled, saturated and presented on a valid/ready output port, giving a decimated, demodulated in-phase stream for the OCT fringe-processing chain.

## Interface
- ADC_W, 14, ADC sample width (signed two's complement)
- NCO_W, 13, NCO sine width (signed two's complement)
- DEC_LOG2, 6, log2 of decimation ratio N (N = 64)
- SHIFT, 15, arithmetic right shift applied to each dumped sum
- OUT_W, 16, output width (signed)

- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  run control; low forces IDLE
- adc_data  in  ADC_W  signed ADC sample
- adc_valid  in  1  adc_data qualifier
- nco_sin  in  NCO_W  signed sine from NCO
- nco_valid  in  1  NCO out_valid
- out_data  out  OUT_W  signed decimated result
- out_valid  out  1  result pending
- out_ready  in  1  consumer accepts result
- overflow  out  1  sticky: a result was saturated
- dropped  out  1  sticky: a result was lost to backpressure
- busy  out  1  high in ACCUM

## Operation
- FSM states: IDLE, ACCUM.
  - IDLE → ACCUM when enable = 1.
  - ACCUM → IDLE when enable = 0. On that transition the accumulator, sample counter and product stage are cleared, and any partial frame is discarded.
  - The output register is never cleared by enable.
- Accept condition: state = ACCUM & enable & adc_valid & nco_valid. Cycles without acceptance do not advance the counter.
- Stage 1: the accepted product adc_data × nco_sin is registered, signed and full precision at ADC_W+NCO_W bits, together with a product-valid bit.
- Stage 2: each valid product is added to the accumulator, which is ADC_W+NCO_W+DEC_LOG2 bits signed, so no internal wrap is possible. A DEC_LOG2-bit counter increments on each add.
- Dump occurs on the Nth product (counter = N−1):
  - sum = acc + product, then >>> SHIFT. Truncation is toward −∞; there is no rounding.
  - The result is saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - The accumulator and counter restart at 0 in the same cycle, so the next frame's first product can add on the following cycle without a gap.
- Saturation on a dump sets overflow.
- Output buffer is a single entry:
  - out_data is stable while out_valid = 1.
  - A transfer occurs when out_valid & out_ready are high at an edge.
  - Dump while empty, or while full with out_ready = 1: load the new result and keep out_valid = 1.
  - Dump while full with out_ready = 0: discard the new result, keep the old one, and set dropped.
- overflow and dropped clear only on reset.
- Reset values: out_data 0, out_valid 0, overflow 0, dropped 0, busy 0. Reset also clears the FSM to IDLE and clears the accumulator, counter and product stage.

## Timing
- Edge k captures the Nth accepted sample.
- Edge k+1 loads out_data and raises out_valid.
- Latency from Nth sample to out_valid is 2 clocks.
- Continuous input yields exactly one result every N clocks.
- busy rises 1 clock after enable rises, and falls 1 clock after enable falls.
- Reset asserted at any cycle takes effect at the next edge and overrides every other event.

## Test plan
- DC positive: adc = 1000, nco = 2047, both valid continuously, out_ready = 1 → out_data = 3998 every 64 clocks, overflow = 0.
- DC negative / floor: adc = −1000, nco = 2047 → out_data = −3999 (floor of −3998.04).
- Saturation: adc = 8191, nco = 4095 → raw 65512, so out_data = 32767 and overflow = 1. Then adc = −8192, nco = 4095 → out_data = −32768.
- Gapped input and backpressure:
  - adc_valid toggling every other cycle → still exactly 64 products per result; out_valid first rises 2 clocks after the 64th accepted sample.
  - out_ready = 0 across two dumps → first result held, second lost, dropped = 1.
- Abort: enable = 0 after 30 samples, then re-enabled → no output until 64 new samples; with adc = 1000, nco = 2047 the result is exactly 3998.
- Reset mid-frame with out_valid = 1 → all outputs return to 0 on the next edge, and the next result requires 64 fresh samples.

Source files
------------

// File: rtl/nco_mix_decim.sv
// Mixes signed ADC samples with the NCO sine and boxcar-decimates by 2^DEC_LOG2.
// Each dumped sum is shifted, saturated and held in a single-entry valid/ready output buffer.
module nco_mix_decim #(
    parameter int ADC_W    = 14,
    parameter int NCO_W    = 13,
    parameter int DEC_LOG2 = 6,
    parameter int SHIFT    = 15,
    parameter int OUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic                    adc_valid,
    input  logic signed [NCO_W-1:0] nco_sin,
    input  logic                    nco_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic                    dropped,
    output logic                    busy
);

    localparam int PROD_W = ADC_W + NCO_W;
    localparam int ACC_W  = PROD_W + DEC_LOG2;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state_reg, state_next;
    logic signed [PROD_W-1:0]  prod_reg;
    logic                      prod_valid_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic [DEC_LOG2-1:0]       cnt_reg;
    logic signed [OUT_W-1:0]   out_data_reg;
    logic                      out_valid_reg;
    logic                      overflow_reg;
    logic                      dropped_reg;

    logic                      accept;
    logic                      abort;
    logic                      dump;
    logic                      fits;
    logic signed [PROD_W-1:0]  prod_next;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic [ACC_W-OUT_W:0]      top_bits;
    logic signed [OUT_W-1:0]   sat_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (enable)  state_next = ACCUM;
            ACCUM:   if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign abort     = (state_reg == ACCUM) && !enable;
    assign accept    = (state_reg == ACCUM) && enable && adc_valid && nco_valid;
    assign prod_next = adc_data * nco_sin;

    // Dumped sum uses the incoming product so the accumulator can restart with no gap.
    assign prod_ext = {{DEC_LOG2{prod_reg[PROD_W-1]}}, prod_reg};
    assign sum      = acc_reg + prod_ext;
    assign shifted  = sum >>> SHIFT;
    assign top_bits = shifted[ACC_W-1:OUT_W-1];
    assign fits     = (&top_bits) | ~(|top_bits);
    assign sat_data = fits ? shifted[OUT_W-1:0]
                    : (shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}});
    assign dump     = prod_valid_reg && !abort && (&cnt_reg);

    always_ff @(posedge clk) begin
        if (!reset_n || abort) begin
            prod_reg       <= '0;
            prod_valid_reg <= 1'b0;
        end else begin
            prod_valid_reg <= accept;
            if (accept) begin
                prod_reg <= prod_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || abort) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (prod_valid_reg) begin
            if (dump) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= sum;
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            dropped_reg   <= 1'b0;
        end else if (dump) begin
            if (!fits) begin
                overflow_reg <= 1'b1;
            end
            if (!out_valid_reg || out_ready) begin
                out_data_reg  <= sat_data;
                out_valid_reg <= 1'b1;
            end else begin
                dropped_reg <= 1'b1;
            end
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign overflow  = overflow_reg;
    assign dropped   = dropped_reg;
    assign busy      = (state_reg == ACCUM);

endmodule

// File: tb/tb_nco_mix_decim.sv
// Scoreboard bench for nco_mix_decim: stimulus pushes expected results, a monitor pops on each transfer.
module tb_nco_mix_decim;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic signed [13:0] adc_data;
    logic               adc_valid;
    logic signed [12:0] nco_sin;
    logic               nco_valid;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic               dropped;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    nco_mix_decim dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .nco_sin   (nco_sin),
        .nco_valid (nco_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .dropped   (dropped),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready are seen here.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_data: unexpected result %0d, none expected", out_data);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'(out_data) != e) begin
                    bad++;
                    $display("FAIL out_data: got %0d expected %0d", out_data, e);
                end else begin
                    $display("ok   out_data: %0d", out_data);
                end
            end
        end
    end

    // Called at #1 after a rising edge; leaves the bench at #1 after the last capturing edge.
    task automatic feed(input int n, input int a, input int b, input bit gap);
        for (int i = 0; i < n; i++) begin
            adc_data  = 14'(a);
            nco_sin   = 13'(b);
            adc_valid = 1'b1;
            nco_valid = 1'b1;
            @(posedge clk); #1;
            if (gap) begin
                adc_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_empty(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        idle(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d results still pending after timeout, expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        nco_sin   = '0;
        nco_valid = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("reset out_data", out_data, 0);
        check("reset out_valid", out_valid, 0);
        check("reset overflow", overflow, 0);
        check("reset dropped", dropped, 0);
        check("reset busy", busy, 0);
        reset_n = 1'b1;
        idle(1);

        // busy follows enable by one clock
        enable = 1'b1;
        check("busy before edge", busy, 0);
        idle(1);
        check("busy after enable", busy, 1);

        // DC positive, two back-to-back frames
        exp_q.push_back(3998);
        exp_q.push_back(3998);
        feed(128, 1000, 2047, 1'b0);
        wait_empty("dc positive");

        // DC negative, floor toward -inf
        exp_q.push_back(-3999);
        feed(64, -1000, 2047, 1'b0);
        wait_empty("dc negative");
        check("overflow clean", overflow, 0);

        // Saturation both ways
        exp_q.push_back(32767);
        feed(64, 8191, 4095, 1'b0);
        wait_empty("sat positive");
        check("overflow set", overflow, 1);
        exp_q.push_back(-32768);
        feed(64, -8192, 4095, 1'b0);
        wait_empty("sat negative");

        // Gapped input: 64 accepted samples, out_valid 2 clocks after the last
        exp_q.push_back(3998);
        feed(63, 1000, 2047, 1'b1);
        check("gapped no early output", out_valid, 0);
        feed(1, 1000, 2047, 1'b0);
        check("gapped latency 1 clk", out_valid, 0);
        idle(1);
        check("gapped latency 2 clk", out_valid, 1);
        wait_empty("gapped");

        // Backpressure across two dumps: first held, second dropped
        check("dropped clean", dropped, 0);
        out_ready = 1'b0;
        exp_q.push_back(3998);
        feed(64, 1000, 2047, 1'b0);
        feed(64, -1000, 2047, 1'b0);
        idle(2);
        check("bp held valid", out_valid, 1);
        check("bp held data", out_data, 3998);
        check("bp dropped", dropped, 1);
        out_ready = 1'b1;
        wait_empty("backpressure");
        check("bp dropped sticky", dropped, 1);

        // Abort a partial frame, then a clean frame must follow
        feed(30, 5000, 4095, 1'b0);
        enable = 1'b0;
        check("busy held on disable", busy, 1);
        idle(1);
        check("busy falls", busy, 0);
        idle(3);
        enable = 1'b1;
        idle(1);
        feed(63, 1000, 2047, 1'b0);
        idle(4);
        check("abort no early output", out_valid, 0);
        exp_q.push_back(3998);
        feed(1, 1000, 2047, 1'b0);
        wait_empty("abort");

        // Reset mid-frame with a result pending
        out_ready = 1'b0;
        feed(64, 1000, 2047, 1'b0);
        idle(2);
        check("pre-reset valid", out_valid, 1);
        feed(20, 1000, 2047, 1'b0);
        reset_n = 1'b0;
        idle(1);
        check("mid reset out_data", out_data, 0);
        check("mid reset out_valid", out_valid, 0);
        check("mid reset overflow", overflow, 0);
        check("mid reset dropped", dropped, 0);
        check("mid reset busy", busy, 0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("post reset busy", busy, 1);
        feed(63, -1000, 2047, 1'b0);
        idle(4);
        check("post reset no early output", out_valid, 0);
        exp_q.push_back(-3999);
        feed(1, -1000, 2047, 1'b0);
        wait_empty("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
